// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage: MIPS32 field positions,
// supported opcodes and the decoded control part of the operand bundle.
package operand_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int REG_AW  = 5;
    localparam int IMM_W   = 16;

    // Instruction field bit positions
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    // Supported opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    typedef enum logic [1:0] {
        B_SRC_REG  = 2'd0,
        B_SRC_SEXT = 2'd1,
        B_SRC_ZEXT = 2'd2
    } b_src_e;

    // Control half of the operand bundle; the data operands A/B are held
    // next to it because their width is a parameter of the stage.
    typedef struct packed {
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dest;
        logic [IMM_W-1:0]  imm;
        b_src_e            b_src;
        logic              illegal;
    } of_ctrl_t;

    // Unsupported opcodes still produce a bundle: B takes the sign-extended
    // immediate and nothing is written back.
    function automatic of_ctrl_t decode_instr(input logic [INSTR_W-1:0] instr);
        of_ctrl_t d;
        d         = '0;
        d.opcode  = instr[OPC_MSB:OPC_LSB];
        d.funct   = instr[FUNCT_MSB:FUNCT_LSB];
        d.rs      = instr[RS_MSB:RS_LSB];
        d.rt      = instr[RT_MSB:RT_LSB];
        d.imm     = instr[IMM_MSB:IMM_LSB];
        d.b_src   = B_SRC_SEXT;
        d.dest    = '0;
        d.illegal = 1'b0;
        case (instr[OPC_MSB:OPC_LSB])
            OPC_RTYPE: begin
                d.b_src = B_SRC_REG;
                d.dest  = instr[RD_MSB:RD_LSB];
            end
            OPC_BEQ: begin
                d.b_src = B_SRC_REG;
            end
            OPC_ADDI, OPC_SLTI, OPC_LW: begin
                d.b_src = B_SRC_SEXT;
                d.dest  = instr[RT_MSB:RT_LSB];
            end
            OPC_ANDI, OPC_ORI: begin
                d.b_src = B_SRC_ZEXT;
                d.dest  = instr[RT_MSB:RT_LSB];
            end
            OPC_SW: begin
                d.b_src = B_SRC_SEXT;
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// Architectural register file: two combinational read ports, one write port.
// Register 0 always reads as zero and ignores writes.
module reg_file
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_ra,
    output logic [DATA_W-1:0] o_rd_a,
    input  logic [REG_AW-1:0] i_rb,
    output logic [DATA_W-1:0] o_rd_b,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_mem [REG_CNT];
    logic              w_wr;

    assign w_wr = i_we && (i_waddr != '0);

    // Storage: reset clears every entry and blocks writes in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rd_a = (i_ra == '0) ? '0 : r_mem[i_ra];
    assign o_rd_b = (i_rb == '0) ? '0 : r_mem[i_rb];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: decodes a MIPS32 word, reads rs/rt with write-through
// bypass, and presents a registered operand bundle to the ALU under a
// valid/ready handshake. A held bundle keeps tracking writebacks to its
// source registers so the ALU never consumes a stale operand.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         opcode,
    output logic [5:0]         func_field,
    output logic [DATA_W-1:0]  A,
    output logic [DATA_W-1:0]  B,
    output logic [REG_AW-1:0]  dest,
    output logic               illegal
);

    of_ctrl_t          w_dec;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic              w_wb_hit;
    logic [DATA_W-1:0] w_imm_sext;
    logic [DATA_W-1:0] w_imm_zext;
    logic [DATA_W-1:0] w_a_next;
    logic [DATA_W-1:0] w_b_reg;
    logic [DATA_W-1:0] w_b_next;
    logic              w_capture;
    logic              w_hold;
    logic              w_refresh_a;
    logic              w_refresh_b;

    logic              r_valid;
    of_ctrl_t          r_ctrl;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;

    assign w_dec = decode_instr(instr);

    reg_file #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .i_ra    (w_dec.rs),
        .o_rd_a  (w_rd_a),
        .i_rb    (w_dec.rt),
        .o_rd_b  (w_rd_b),
        .i_we    (wb_en),
        .i_waddr (wb_addr),
        .i_wdata (wb_data)
    );

    // A writeback to r0 never lands, so it must not bypass either
    assign w_wb_hit   = wb_en && (wb_addr != '0);

    assign w_imm_sext = {{(DATA_W-IMM_W){w_dec.imm[IMM_W-1]}}, w_dec.imm};
    assign w_imm_zext = {{(DATA_W-IMM_W){1'b0}}, w_dec.imm};

    assign w_a_next   = (w_wb_hit && (wb_addr == w_dec.rs)) ? wb_data : w_rd_a;
    assign w_b_reg    = (w_wb_hit && (wb_addr == w_dec.rt)) ? wb_data : w_rd_b;

    // Operand B source selection for the incoming instruction
    always_comb begin
        w_b_next = w_imm_sext;
        case (w_dec.b_src)
            B_SRC_REG:  w_b_next = w_b_reg;
            B_SRC_ZEXT: w_b_next = w_imm_zext;
            default:    w_b_next = w_imm_sext;
        endcase
    end

    assign in_ready    = !r_valid || out_ready;
    assign w_capture   = in_valid && in_ready;
    assign w_hold      = r_valid && !out_ready;

    // While stalled, only the register-sourced operands follow writebacks
    assign w_refresh_a = w_hold && w_wb_hit && (wb_addr == r_ctrl.rs);
    assign w_refresh_b = w_hold && w_wb_hit && (r_ctrl.b_src == B_SRC_REG)
                         && (wb_addr == r_ctrl.rt);

    // Handshake state and control fields of the bundle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_dec;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Operand A: a new capture takes priority over refreshing a held value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
        end else if (w_capture) begin
            r_a <= w_a_next;
        end else if (w_refresh_a) begin
            r_a <= wb_data;
        end
    end

    // Operand B: same priority as A
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b <= '0;
        end else if (w_capture) begin
            r_b <= w_b_next;
        end else if (w_refresh_b) begin
            r_b <= wb_data;
        end
    end

    assign out_valid  = r_valid;
    assign opcode     = r_ctrl.opcode;
    assign func_field = r_ctrl.funct;
    assign dest       = r_ctrl.dest;
    assign illegal    = r_ctrl.illegal;
    assign A          = r_a;
    assign B          = r_b;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: DATA_W, 32, operand and register width.
REQ-002 Parameter: REG_CNT, 32, number of architectural registers; register 0 is hardwired to zero.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  decoded instruction present on instr.
REQ-006 in_ready  out  1  stage accepts instr this cycle.
REQ-007 instr  in  32  MIPS32 word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0], funct[5:0].
REQ-008 wb_en  in  1  register writeback strobe.
REQ-009 wb_addr  in  5  writeback register index.
REQ-010 wb_data  in  DATA_W  writeback value.
REQ-011 out_valid  out  1  operand bundle valid for the ALU.
REQ-012 out_ready  in  1  ALU stage consumes the bundle.
REQ-013 opcode  out  6  captured opcode, driven to ALU control.
REQ-014 func_field  out  6  captured funct, driven to ALU control.
REQ-015 A  out  DATA_W  ALU operand A = rf[rs].
REQ-016 B  out  DATA_W  ALU operand B (selection per REQ-022).
REQ-017 dest  out  5  destination register index for writeback.
REQ-018 illegal  out  1  captured opcode is unsupported.

Function
REQ-019 Register file SHALL be REG_CNT x DATA_W, with 2 read ports and 1 write port; a read of index 0 returns 0; a write to index 0 is ignored.
REQ-020 A write SHALL occur on the edge where wb_en=1 and wb_addr!=0.
REQ-021 in_ready SHALL equal !out_valid | out_ready; capture SHALL occur when in_valid & in_ready; bundle latency is exactly 1 cycle.
REQ-022 B selection:
- opcode 0x00 (R-type) and 0x04 (beq): B = rf[rt].
- 0x08, 0x0A, 0x23, 0x2B: B = sign-extended imm.
- 0x0C, 0x0D: B = zero-extended imm.
REQ-023 dest selection: R-type gives rd; 0x08/0x0A/0x0C/0x0D/0x23 give rt; 0x2B/0x04 give 0.
REQ-024 Any other opcode SHALL give illegal=1, B = sign-extended imm, dest=0; the bundle still flows.
REQ-025 Write-through bypass: if wb_en & wb_addr!=0 & wb_addr matches rs (or rt) in the capture cycle, A (or B, when register-sourced) SHALL take wb_data.
REQ-026 Held refresh: while out_valid & !out_ready, a writeback matching the held rs (or the held register-sourced rt) SHALL update A (or B) on the next edge; all other outputs stay stable.
REQ-027 Capture and held refresh in the same cycle: the new capture SHALL win.
REQ-028 out_valid SHALL clear after out_ready when no new capture occurs in that cycle; back-to-back captures SHALL sustain 1 bundle/cycle.

Reset
REQ-029 On rst=1 at an edge: out_valid=0, A=B=0, opcode=func_field=0, dest=0, illegal=0, and all registers cleared to 0.
REQ-030 In-flight and held bundles SHALL be dropped on reset, and writebacks asserted during reset SHALL be ignored.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 Shared package SHALL hold the opcode constants (R-type, addi, slti, andi, ori, lw, sw, beq), field bit-slice positions, and a typedef for the operand bundle.
REQ-033 One sub-module SHALL exist: reg_file (2R1W, zero-register rule); the bypass, decode, and output register live in operand_fetch.

Verification
REQ-034 Reset, then write wb r5=0x0000_0010; capture add r3,r5,r5 (0x00A51820) -> next cycle out_valid=1, A=B=0x10, dest=3, func_field=0x20.
REQ-035 addi r2,r0,-1 (0x2002FFFF) -> A=0, B=0xFFFF_FFFF, dest=2; ori r2,r0,0xFFFF -> B=0x0000_FFFF.
REQ-036 Capture add r1,r5,r6 while wb_en r5=0xDEAD_BEEF in the same cycle -> A=0xDEAD_BEEF.
REQ-037 Hold out_ready=0 for 3 cycles with bundle rs=r7, then writeback r7=0x55 -> A=0x55 next cycle; in_ready=0 throughout; other fields unchanged.
REQ-038 Write r0=0x1234, then read r0 -> A=0; opcode 0x3F -> illegal=1, dest=0; assert rst with out_valid=1 -> next cycle out_valid=0 and rf[5]=0.
